// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Command word = one R/W bit followed by the start address.
    function automatic int cmd_len(input int addr_w);
        return 1 + addr_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus one-clock rise/fall pulses.
// Latency: pin change to pulse visible is STAGES clocks; pulse acted on at STAGES+1.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchroniser and remember the last synced level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// Mode-0 SPI slave fronting a DEPTH-entry register file with burst auto-increment and wrap.
// Latency: pin event to action SYNC_STAGES+1 clocks; last write bit to wr_stb_o 1 clock.
// Backpressure: none; wr_stb_o is a one-cycle pulse the fabric must accept.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              cs_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic              wr_stb_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);

    localparam int CMD_LEN = cmd_len(ADDR_W);
    localparam int SH_W    = (CMD_LEN > DATA_W) ? CMD_LEN : DATA_W;
    localparam int CNT_W   = $clog2(SH_W + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;
    logic cs_low_q;
    logic sample, shift;

    state_e              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [SH_W-1:0]     shift_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   tx_q;
    logic                load_q;
    logic                started_q;
    logic                miso_q;
    logic                oe_q;
    logic                stb_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic [CMD_LEN-1:0]  cmd_word;
    logic [DATA_W-1:0]   rx_word;
    logic                in_range;
    logic [DATA_W-1:0]   rd_word;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .d_i    (sclk_i),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .d_i    (cs_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI only needs synchronising; it is sampled on the SCLK rise pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) mosi_sync_q <= '0;
        else          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Track the previous synced CS level so an SCLK edge landing on the
    // same clock as the CS rise is still honoured before going idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     cs_low_q <= 1'b0;
        else if (cs_fall) cs_low_q <= 1'b1;
        else if (cs_rise) cs_low_q <= 1'b0;
    end

    assign sample   = sclk_rise & cs_low_q;
    assign shift    = sclk_fall & cs_low_q;
    assign cmd_word = {shift_q[CMD_LEN-2:0], mosi_s};
    assign rx_word  = {shift_q[DATA_W-2:0], mosi_s};
    assign in_range = int'(addr_q) < DEPTH;
    assign rd_word  = in_range ? regs_q[addr_q[IDX_W-1:0]] : '0;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (int'(a) == DEPTH - 1) ? '0 : a + ADDR_W'(1);
    endfunction

    // Protocol FSM, register array and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            load_q    <= 1'b0;
            started_q <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            stb_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= CMD;
                        bit_cnt_q <= '0;
                    end
                end
                CMD: begin
                    if (sample) begin
                        shift_q <= {shift_q[SH_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(CMD_LEN - 1)) begin
                            bit_cnt_q <= '0;
                            addr_q    <= cmd_word[ADDR_W-1:0];
                            if (cmd_word[ADDR_W] == RW_READ) begin
                                state_q   <= READ;
                                load_q    <= 1'b1;
                                started_q <= 1'b0;
                            end else begin
                                state_q <= WRITE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (sample) begin
                        shift_q <= {shift_q[SH_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_q <= '0;
                            if (in_range) begin
                                regs_q[addr_q[IDX_W-1:0]] <= rx_word;
                                stb_q     <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= rx_word;
                            end
                            addr_q <= next_addr(addr_q);
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                READ: begin
                    // A fresh word is presented without shifting; the first
                    // shift only follows a data-phase sample of that word.
                    if (load_q) begin
                        tx_q      <= rd_word;
                        miso_q    <= rd_word[DATA_W-1];
                        oe_q      <= 1'b1;
                        load_q    <= 1'b0;
                        started_q <= 1'b0;
                    end else if (shift && started_q) begin
                        tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                        miso_q <= tx_q[DATA_W-2];
                    end
                    if (sample) begin
                        started_q <= 1'b1;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_q <= '0;
                            addr_q    <= next_addr(addr_q);
                            load_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // CS release ends the frame after any same-cycle commit above.
            if (cs_rise) begin
                state_q <= IDLE;
                oe_q    <= 1'b0;
                miso_q  <= 1'b0;
                load_q  <= 1'b0;
            end
        end
    end

    assign miso_o    = miso_q;
    assign miso_oe_o = oe_q;
    assign wr_stb_o  = stb_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule
